// File: rtl/drv_pkg.sv
// Shared types and constants for the non-overlap gate driver.
//   drv_state_e  : per-channel FSM state encoding
//   DrvDtwDefault / DrvDtMinDefault : default dead-time width and floor
//   max_with_min : clamps a dead-time value up to the enforced minimum
package drv_pkg;

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StLsOn = 3'd1,
    StDtR  = 3'd2,
    StHsOn = 3'd3,
    StDtF  = 3'd4
  } drv_state_e;

  localparam int unsigned DrvDtwDefault   = 6;
  localparam int unsigned DrvDtMinDefault = 1;

  function automatic logic [31:0] max_with_min(logic [31:0] val, logic [31:0] min_val);
    return (val < min_val) ? min_val : val;
  endfunction

endpackage

// File: rtl/drv_nonoverlap_chan.sv
// One channel of the non-overlap driver: FSM, dead-time counter, registered gate enables.
//   clk, rst_n            : clock, async active-low reset
//   force_off_i           : en low or fault active/latched; drives the channel to OFF
//   demand_i              : PWM demand (1 = high side, 0 = low side)
//   dt_rise_i / dt_fall_i : dead time before HS / LS turn-on, sampled on entry only
//   hs_o / ls_o           : registered high-side / low-side enables
//   busy_o                : registered, high while in a dead-time state
module drv_nonoverlap_chan
  import drv_pkg::*;
#(
  parameter int unsigned DTW    = DrvDtwDefault,
  parameter int unsigned DT_MIN = DrvDtMinDefault
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           force_off_i,
  input  logic           demand_i,
  input  logic [DTW-1:0] dt_rise_i,
  input  logic [DTW-1:0] dt_fall_i,
  output logic           hs_o,
  output logic           ls_o,
  output logic           busy_o
);

  drv_state_e     state_q, state_d;
  logic [DTW-1:0] cnt_q, cnt_d;
  logic           hs_q, ls_q, busy_q;
  logic [DTW-1:0] load_rise, load_fall;

  assign load_rise = DTW'(max_with_min(32'(dt_rise_i), 32'(DT_MIN)));
  assign load_fall = DTW'(max_with_min(32'(dt_fall_i), 32'(DT_MIN)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_off_i) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          if (demand_i) begin
            state_d = StDtR;
            cnt_d   = load_rise;
          end else begin
            state_d = StLsOn;
          end
        end
        StLsOn: begin
          if (demand_i) begin
            state_d = StDtR;
            cnt_d   = load_rise;
          end
        end
        StDtR: begin
          // Demand reverting aborts the dead time, even on the expiry edge.
          if (!demand_i) begin
            state_d = StLsOn;
            cnt_d   = '0;
          end else if (cnt_q <= DTW'(1)) begin
            state_d = StHsOn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DTW'(1);
          end
        end
        StHsOn: begin
          if (!demand_i) begin
            state_d = StDtF;
            cnt_d   = load_fall;
          end
        end
        StDtF: begin
          if (demand_i) begin
            state_d = StHsOn;
            cnt_d   = '0;
          end else if (cnt_q <= DTW'(1)) begin
            state_d = StLsOn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DTW'(1);
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= (state_d == StHsOn);
      ls_q    <= (state_d == StLsOn);
      busy_q  <= (state_d == StDtR) || (state_d == StDtF);
    end
  end

  assign hs_o   = hs_q;
  assign ls_o   = ls_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/drv_nonoverlap_nch.sv
// N-channel non-overlap gate driver with programmable dead time and latched fault shutdown.
//   clk, rst_n            : clock, async active-low reset
//   CELV, CELG, SUB       : brick supply pins, carried through with no logic
//   en                    : global enable, 0 forces all channels OFF
//   dt_rise / dt_fall     : dead-time counts before HS / LS turn-on
//   i                     : per-channel PWM demand
//   fault / fault_clr     : fault request (level) / latch clear
//   o_hs / o_ls           : registered gate enables per channel
//   busy                  : per-channel dead-time indicator
//   flt_latched           : fault latch state
// Build option: define DRV_SYNC_EN to pass i and fault through 2-flop synchronizers.
module drv_nonoverlap_nch
  import drv_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DTW    = DrvDtwDefault,
  parameter int unsigned DT_MIN = DrvDtMinDefault
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           CELV,
  input  logic           CELG,
  input  logic           SUB,
  input  logic           en,
  input  logic [DTW-1:0] dt_rise,
  input  logic [DTW-1:0] dt_fall,
  input  logic [NCH-1:0] i,
  input  logic           fault,
  input  logic           fault_clr,
  output logic [NCH-1:0] o_hs,
  output logic [NCH-1:0] o_ls,
  output logic [NCH-1:0] busy,
  output logic           flt_latched
);

  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  logic [NCH-1:0] demand;
  logic           fault_s;

`ifdef DRV_SYNC_EN
  logic [NCH-1:0] i_meta_q, i_sync_q;
  logic           fault_meta_q, fault_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_meta_q     <= '0;
      i_sync_q     <= '0;
      fault_meta_q <= 1'b0;
      fault_sync_q <= 1'b0;
    end else begin
      i_meta_q     <= i;
      i_sync_q     <= i_meta_q;
      fault_meta_q <= fault;
      fault_sync_q <= fault_meta_q;
    end
  end

  assign demand  = i_sync_q;
  assign fault_s = fault_sync_q;
`else
  assign demand  = i;
  assign fault_s = fault;
`endif

  logic flt_q, flt_d;

  // Fault has priority over clear.
  always_comb begin
    flt_d = flt_q;
    if (fault_s) begin
      flt_d = 1'b1;
    end else if (fault_clr) begin
      flt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q <= 1'b0;
    end else begin
      flt_q <= flt_d;
    end
  end

  assign flt_latched = flt_q;

  // Latched state (not flt_d) keeps channels in OFF on the clearing edge.
  logic force_off;
  assign force_off = !en || fault_s || flt_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    drv_nonoverlap_chan #(
      .DTW    (DTW),
      .DT_MIN (DT_MIN)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .force_off_i (force_off),
      .demand_i    (demand[c]),
      .dt_rise_i   (dt_rise),
      .dt_fall_i   (dt_fall),
      .hs_o        (o_hs[c]),
      .ls_o        (o_ls[c]),
      .busy_o      (busy[c])
    );
  end

endmodule
